// File: rtl/zbt_point_writer_pkg.sv
// Shared ZBT port widths, clear fill value, writer FSM states and slot-detect helper.
// The display-side ZBT reader imports the same widths from here.
package zbt_point_writer_pkg;

    localparam int ZBT_ADDR_WIDTH = 19;
    localparam int ZBT_DATA_WIDTH = 36;
    localparam logic [ZBT_DATA_WIDTH-1:0] ZBT_CLEAR_VALUE = 36'h0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } wr_state_e;

    // True when the low slot_bits of hcount equal the slot phase.
    function automatic logic is_slot(input logic [10:0] hcount, input int slot_bits,
                                     input int slot_phase);
        logic [10:0] mask;
        mask = (11'd1 << slot_bits) - 11'd1;
        return (hcount & mask) == (11'(slot_phase) & mask);
    endfunction

endpackage

// File: rtl/zbt_point_fifo.sv
// Synchronous point FIFO with a registered head word; a word pushed into an
// empty FIFO is readable on the following cycle.
module zbt_point_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [WIDTH-1:0]      head_q, head_d;
    logic                  do_push, do_pop;

    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign head_data = head_q;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (DEPTH_LOG2 + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (DEPTH_LOG2 + 1)'(1);
        end else begin
            count_d = count_q;
        end
        // The next head slot may be the one being written this very cycle.
        if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/zbt_point_writer.sv
// ZBT write-port generator for the point store: buffers laser points and writes
// one per hcount slot at {y, x}, or sweeps the whole region with a fill value.
module zbt_point_writer
    import zbt_point_writer_pkg::*;
#(
    parameter int X_WIDTH         = 8,
    parameter int Y_WIDTH         = 10,
    parameter int ADDR_WIDTH      = ZBT_ADDR_WIDTH,
    parameter int DATA_WIDTH      = ZBT_DATA_WIDTH,
    parameter int SLOT_BITS       = 2,
    parameter int SLOT_PHASE      = 1,
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = DATA_WIDTH'(ZBT_CLEAR_VALUE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           hcount,
    input  logic                  point_valid,
    output logic                  point_ready,
    input  logic [X_WIDTH-1:0]    point_x,
    input  logic [Y_WIDTH-1:0]    point_y,
    input  logic [DATA_WIDTH-1:0] point_data,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  zbtc_we,
    output logic [ADDR_WIDTH-1:0] zbtc_write_addr,
    output logic [DATA_WIDTH-1:0] zbtc_write_data,
    output logic [7:0]            dropped_count
);

    localparam int PT_WIDTH    = X_WIDTH + Y_WIDTH;
    localparam int ENTRY_WIDTH = PT_WIDTH + DATA_WIDTH;

    wr_state_e               state_q, state_d;
    logic [PT_WIDTH-1:0]     sweep_q, sweep_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [7:0]              drop_q, drop_d;
    logic                    slot_s;
    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_WIDTH-1:0]  fifo_head;

    assign slot_s      = is_slot(hcount, SLOT_BITS, SLOT_PHASE);
    assign point_ready = !fifo_full && !reset && (state_q == ST_IDLE);
    assign fifo_push   = point_valid && point_ready;

    assign clear_busy      = (state_q == ST_CLEAR);
    assign zbtc_we         = we_q;
    assign zbtc_write_addr = addr_q;
    assign zbtc_write_data = data_q;
    assign dropped_count   = drop_q;

    zbt_point_fifo #(
        .WIDTH      (ENTRY_WIDTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({point_y, point_x, point_data}),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (fifo_head)
    );

    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (slot_s && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    we_d     = 1'b1;
                    addr_d   = ADDR_WIDTH'(fifo_head[ENTRY_WIDTH-1:DATA_WIDTH]);
                    data_d   = fifo_head[DATA_WIDTH-1:0];
                end else begin
                    we_d = 1'b0;
                end
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // Queued points wait; the sweep ends after the all-ones address.
                if (slot_s) begin
                    we_d    = 1'b1;
                    addr_d  = ADDR_WIDTH'(sweep_q);
                    data_d  = CLEAR_VALUE;
                    sweep_d = sweep_q + PT_WIDTH'(1);
                    if (sweep_q == '1) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end else begin
                    we_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (point_valid && !point_ready && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sweep_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_zbt_point_writer.sv
// Bench for zbt_point_writer: a default-size instance (a) and a 2x2 instance (b)
// checked every cycle against a queue-based reference model.
module tb_zbt_point_writer;

    localparam logic [35:0] CLR_B = 36'hCAFEF00D1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [10:0] hcount;
    logic        hc_run;

    logic        a_valid, a_ready, a_clear, a_busy, a_we;
    logic [7:0]  a_x;
    logic [9:0]  a_y;
    logic [35:0] a_data, a_wdata;
    logic [18:0] a_addr;
    logic [7:0]  a_drop;

    logic        b_valid, b_ready, b_clear, b_busy, b_we;
    logic [1:0]  b_x, b_y;
    logic [35:0] b_data, b_wdata;
    logic [18:0] b_addr;
    logic [7:0]  b_drop;

    zbt_point_writer u_a (
        .clk(clk), .reset(reset), .hcount(hcount),
        .point_valid(a_valid), .point_ready(a_ready),
        .point_x(a_x), .point_y(a_y), .point_data(a_data),
        .clear_start(a_clear), .clear_busy(a_busy),
        .zbtc_we(a_we), .zbtc_write_addr(a_addr), .zbtc_write_data(a_wdata),
        .dropped_count(a_drop)
    );

    zbt_point_writer #(.X_WIDTH(2), .Y_WIDTH(2), .CLEAR_VALUE(CLR_B)) u_b (
        .clk(clk), .reset(reset), .hcount(hcount),
        .point_valid(b_valid), .point_ready(b_ready),
        .point_x(b_x), .point_y(b_y), .point_data(b_data),
        .clear_start(b_clear), .clear_busy(b_busy),
        .zbtc_we(b_we), .zbtc_write_addr(b_addr), .zbtc_write_data(b_wdata),
        .dropped_count(b_drop)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          chk_en = 1'b0;

    // Reference model: a point queue per instance plus the expected write outputs.
    int          qx [2][8];
    int          qy [2][8];
    logic [35:0] qd [2][8];
    int          qh [2];
    int          qn [2];
    bit          m_we [2];
    logic [18:0] m_addr [2];
    logic [35:0] m_data [2];
    bit          m_clr [2];
    int          m_sweep [2];
    int          m_drop [2];
    int          wr_cnt [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(input int k);
        return !reset && !m_clr[k] && (qn[k] < 8);
    endfunction

    task automatic model_step(input int k, input bit v, input int x, input int y,
                              input logic [35:0] d, input bit clr, input int xw,
                              input int yw, input logic [35:0] cv);
        bit rdy;
        bit slot;
        int idx;
        rdy = model_ready(k);
        if (reset) begin
            qn[k] = 0; qh[k] = 0; m_we[k] = 1'b0; m_addr[k] = '0; m_data[k] = '0;
            m_clr[k] = 1'b0; m_sweep[k] = 0; m_drop[k] = 0;
            return;
        end
        slot = ((hcount % 4) == 1);
        if (v && !rdy && m_drop[k] < 255) m_drop[k]++;
        m_we[k] = 1'b0;
        if (!m_clr[k]) begin
            if (slot && qn[k] > 0) begin
                m_we[k]   = 1'b1;
                m_addr[k] = 19'((qy[k][qh[k]] << xw) | qx[k][qh[k]]);
                m_data[k] = qd[k][qh[k]];
                qh[k] = (qh[k] + 1) % 8;
                qn[k]--;
            end
            if (v && rdy) begin
                idx = (qh[k] + qn[k]) % 8;
                qx[k][idx] = x; qy[k][idx] = y; qd[k][idx] = d;
                qn[k]++;
            end
            if (clr) begin
                m_clr[k] = 1'b1;
                m_sweep[k] = 0;
            end
        end else if (slot) begin
            m_we[k]   = 1'b1;
            m_addr[k] = 19'(m_sweep[k]);
            m_data[k] = cv;
            if (m_sweep[k] == (1 << (xw + yw)) - 1) m_clr[k] = 1'b0;
            else m_sweep[k]++;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_we",    64'(a_we),    64'(m_we[0]));
            check("a_addr",  64'(a_addr),  64'(m_addr[0]));
            check("a_data",  64'(a_wdata), 64'(m_data[0]));
            check("a_busy",  64'(a_busy),  64'(m_clr[0]));
            check("a_drop",  64'(a_drop),  64'(m_drop[0]));
            check("a_ready", 64'(a_ready), 64'(model_ready(0)));
            check("b_we",    64'(b_we),    64'(m_we[1]));
            check("b_addr",  64'(b_addr),  64'(m_addr[1]));
            check("b_data",  64'(b_wdata), 64'(m_data[1]));
            check("b_busy",  64'(b_busy),  64'(m_clr[1]));
            check("b_drop",  64'(b_drop),  64'(m_drop[1]));
            check("b_ready", 64'(b_ready), 64'(model_ready(1)));
        end
        if (a_we === 1'b1) wr_cnt[0]++;
        if (b_we === 1'b1) wr_cnt[1]++;
        model_step(0, a_valid, int'(a_x), int'(a_y), a_data, a_clear, 8, 10, 36'h0);
        model_step(1, b_valid, int'(b_x), int'(b_y), b_data, b_clear, 2, 2, CLR_B);
    end

    function automatic logic [35:0] rnd36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        if (hc_run) hcount = hcount + 11'd1;
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 8; i++) begin
            if (hcount[1:0] == 2'(ph)) break;
            cyc();
        end
    endtask

    initial begin
        int n;
        int guard;
        int w0;
        bit acc;
        reset = 1'b1; hcount = 11'd0; hc_run = 1'b1;
        a_valid = 1'b0; a_x = 8'd0; a_y = 10'd0; a_data = 36'd0; a_clear = 1'b0;
        b_valid = 1'b0; b_x = 2'd0; b_y = 2'd0; b_data = 36'd0; b_clear = 1'b0;
        for (int k = 0; k < 2; k++) wr_cnt[k] = 0;
        repeat (3) cyc();
        chk_en = 1'b1;
        reset = 1'b0;
        repeat (4) cyc();

        // Single point pushed at phase 0: write two cycles later, then held.
        wait_phase(0);
        a_valid = 1'b1; a_x = 8'h12; a_y = 10'h034; a_data = 36'hA5A5A5A5A;
        cyc();
        a_valid = 1'b0;
        cyc();
        check("single_we",   64'(a_we),    64'(1'b1));
        check("single_addr", 64'(a_addr),  64'(19'h03412));
        check("single_data", 64'(a_wdata), 64'(36'hA5A5A5A5A));
        cyc();
        check("single_we_low", 64'(a_we),   64'(1'b0));
        check("single_hold",   64'(a_addr), 64'(19'h03412));

        // Burst of 10 points with valid held until each is accepted.
        w0 = wr_cnt[0]; n = 0; guard = 0;
        a_valid = 1'b1; a_x = 8'($urandom); a_y = 10'($urandom); a_data = rnd36();
        while (n < 10 && guard < 300) begin
            acc = a_ready;
            cyc();
            guard++;
            if (acc) begin
                n++;
                a_x = 8'($urandom); a_y = 10'($urandom); a_data = rnd36();
            end
        end
        a_valid = 1'b0;
        check("burst_accepted", 64'(n), 64'(10));
        repeat (60) cyc();
        check("burst_writes", 64'(wr_cnt[0] - w0), 64'(10));

        // Drops with the slot frozen out: fill 8, then 5 drops, then saturate.
        wait_phase(0);
        hc_run = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        a_valid = 1'b1;
        for (int i = 0; i < 13; i++) begin
            a_x = 8'($urandom); a_y = 10'($urandom); a_data = rnd36();
            cyc();
        end
        check("drop_five", 64'(a_drop), 64'(8'd5));
        repeat (300) cyc();
        check("drop_sat", 64'(a_drop), 64'(8'd255));
        a_valid = 1'b0;
        hc_run = 1'b1;
        repeat (40) cyc();

        // Full sweep on the 2x2 instance.
        w0 = wr_cnt[1];
        b_clear = 1'b1;
        cyc();
        b_clear = 1'b0;
        repeat (70) cyc();
        check("sweep_writes", 64'(wr_cnt[1] - w0), 64'(16));
        check("sweep_busy_low", 64'(b_busy), 64'(1'b0));
        check("sweep_ready", 64'(b_ready), 64'(1'b1));

        // Points queued before a sweep are held; a second clear_start is ignored.
        wait_phase(0);
        hc_run = 1'b0;
        w0 = wr_cnt[1];
        b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_x = 2'($urandom); b_y = 2'($urandom); b_data = rnd36();
            cyc();
        end
        b_valid = 1'b0;
        b_clear = 1'b1;
        cyc();
        b_clear = 1'b0;
        hc_run = 1'b1;
        repeat (30) cyc();
        b_clear = 1'b1;
        cyc();
        b_clear = 1'b0;
        repeat (70) cyc();
        check("held_writes", 64'(wr_cnt[1] - w0), 64'(19));

        // Reset on the 5th clear write discards the sweep and the queued points.
        wait_phase(0);
        hc_run = 1'b0;
        b_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            b_x = 2'($urandom); b_y = 2'($urandom); b_data = rnd36();
            cyc();
        end
        b_valid = 1'b0;
        b_clear = 1'b1;
        cyc();
        b_clear = 1'b0;
        hc_run = 1'b1;
        n = 0; guard = 0;
        while (n < 5 && guard < 100) begin
            cyc();
            guard++;
            if (b_we === 1'b1) n++;
        end
        check("reset_reach_5th", 64'(n), 64'(5));
        reset = 1'b1;
        cyc();
        check("rst_we",   64'(b_we),    64'(1'b0));
        check("rst_addr", 64'(b_addr),  64'(19'd0));
        check("rst_data", 64'(b_wdata), 64'(36'd0));
        check("rst_busy", 64'(b_busy),  64'(1'b0));
        reset = 1'b0;
        w0 = wr_cnt[1];
        repeat (40) cyc();
        check("post_reset_writes", 64'(wr_cnt[1] - w0), 64'(0));

        // Randomized traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            a_valid = 1'($urandom); a_x = 8'($urandom); a_y = 10'($urandom); a_data = rnd36();
            b_valid = 1'($urandom); b_x = 2'($urandom); b_y = 2'($urandom); b_data = rnd36();
            b_clear = ($urandom_range(0, 63) == 0);
            cyc();
        end
        a_valid = 1'b0; b_valid = 1'b0; b_clear = 1'b0;
        repeat (120) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
